// File: rtl/uart_speed_rx_pkg.sv
// rtl/uart_speed_rx_pkg.sv - shared constants and state encodings for the speed record receiver
// Contents:
//   HDR_BYTE      record header byte
//   TIMEOUT_BITS  inter-byte timeout, in bit times
//   byte_state_t  byte receiver states
//   pkt_state_t   record parser states
//   rec_chk()     expected checksum byte for a HI/LO pair
package uart_speed_rx_pkg;

  localparam logic [7:0] HDR_BYTE     = 8'hA5;
  localparam int         TIMEOUT_BITS = 40;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } byte_state_t;

  typedef enum logic [1:0] {
    WAIT_HDR,
    GET_HI,
    GET_LO,
    GET_CHK
  } pkt_state_t;

  function automatic logic [7:0] rec_chk(input logic [7:0] hi, input logic [7:0] lo);
    return HDR_BYTE ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchronizer
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   rx           asynchronous serial line, idle high
//   data         last received byte, valid while byte_strobe is high
//   byte_strobe  one-cycle pulse, good stop bit
//   stop_err     one-cycle pulse, stop bit sampled low
module uart_rx_byte
  import uart_speed_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_strobe,
  output logic       stop_err
);

  localparam int              CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  byte_state_t   state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          strobe_q, err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q  <= rx;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          // Only a real high-to-low transition starts a byte, so a line held
          // low after a framing error does not retrigger.
          if (prev_q && !sync2_q) state_q <= START;
        end
        START: begin
          if (baud_cnt_q == HALF_M1) begin
            baud_cnt_q <= '0;
            state_q    <= sync2_q ? IDLE : DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt_q == FULL_M1) begin
            baud_cnt_q <= '0;
            shift_q    <= {sync2_q, shift_q[7:1]};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt_q == FULL_M1) begin
            baud_cnt_q <= '0;
            strobe_q   <= sync2_q;
            err_q      <= !sync2_q;
            state_q    <= IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data        = shift_q;
  assign byte_strobe = strobe_q;
  assign stop_err    = err_q;

endmodule

// File: rtl/uart_speed_rx.sv
// rtl/uart_speed_rx.sv - decodes 4-byte speed records (A5, HI, LO, CHK) from a UART line
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous active-high reset
//   serial_data_in  asynchronous UART line, 8N1, idle high
//   speed           last valid speed, held between records
//   speed_valid     one-cycle pulse when speed updates
//   frame_err       one-cycle pulse on a bad stop bit
//   chk_err         one-cycle pulse on a checksum mismatch
module uart_speed_rx
  import uart_speed_rx_pkg::*;
#(
  parameter int SYS_FREQ    = 50000000,
  parameter int BAUD        = 9600,
  parameter int WIDTH_SPEED = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serial_data_in,
  output logic [WIDTH_SPEED-1:0] speed,
  output logic                   speed_valid,
  output logic                   frame_err,
  output logic                   chk_err
);

  localparam int            CLKS_PER_BIT = SYS_FREQ / BAUD;
  localparam int            TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TIMEOUT_M1   = TW'(TIMEOUT_CLKS - 1);

  logic [7:0] rx_data;
  logic       byte_strobe, stop_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .reset      (reset),
    .rx         (serial_data_in),
    .data       (rx_data),
    .byte_strobe(byte_strobe),
    .stop_err   (stop_err)
  );

  pkt_state_t             state_q;
  logic [7:0]             hi_q, lo_q;
  logic [TW-1:0]          tmo_q;
  logic [WIDTH_SPEED-1:0] speed_q;
  logic                   valid_q, ferr_q, cerr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_HDR;
      hi_q    <= '0;
      lo_q    <= '0;
      tmo_q   <= '0;
      speed_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      cerr_q  <= 1'b0;
      if (stop_err) begin
        ferr_q  <= 1'b1;
        state_q <= WAIT_HDR;
        tmo_q   <= '0;
      end else if (byte_strobe) begin
        tmo_q <= '0;
        case (state_q)
          WAIT_HDR: if (rx_data == HDR_BYTE) state_q <= GET_HI;
          GET_HI: begin
            hi_q    <= rx_data;
            state_q <= GET_LO;
          end
          GET_LO: begin
            lo_q    <= rx_data;
            state_q <= GET_CHK;
          end
          GET_CHK: begin
            // Checksum covers all of HI, including the two bits dropped from speed.
            if (rx_data == rec_chk(hi_q, lo_q)) begin
              speed_q <= WIDTH_SPEED'({hi_q[5:0], lo_q});
              valid_q <= 1'b1;
            end else begin
              cerr_q <= 1'b1;
            end
            state_q <= WAIT_HDR;
          end
          default: state_q <= WAIT_HDR;
        endcase
      end else if (state_q != WAIT_HDR) begin
        // A stalled record is abandoned quietly.
        if (tmo_q == TIMEOUT_M1) begin
          state_q <= WAIT_HDR;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign speed       = speed_q;
  assign speed_valid = valid_q;
  assign frame_err   = ferr_q;
  assign chk_err     = cerr_q;

endmodule

// File: doc/uart_speed_rx.md
UART_SPEED_RX -- requirements
Module: uart_speed_rx

Interface
REQ-001 Parameter SYS_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter WIDTH_SPEED, default 14, width of the reassembled speed word.
REQ-004 Port clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port serial_data_in  input  1  asynchronous UART line (8N1, LSB first, idle high), driven from the toll system's serial_data_out.
REQ-007 Port speed  output  WIDTH_SPEED  last valid speed value; held until the next valid record.
REQ-008 Port speed_valid  output  1  one-cycle pulse; speed updated in the same cycle.
REQ-009 Port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 Port chk_err  output  1  one-cycle pulse on a checksum mismatch.

Function
REQ-011 serial_data_in SHALL pass through a 2-flop synchronizer before any use.
REQ-012 CLKS_PER_BIT SHALL equal SYS_FREQ/BAUD (integer divide), e.g. 5208 at the default parameter values.
REQ-013 Byte FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE->START SHALL occur on a synchronized high-to-low transition.
REQ-015 In START, the line SHALL be resampled at CLKS_PER_BIT/2: if low, go to DATA; if high, treat as a glitch and return to IDLE with no error.
REQ-016 In DATA, 8 bits SHALL be sampled LSB first, each at CLKS_PER_BIT after the previous sample.
REQ-017 In STOP, the line SHALL be sampled once: if high, a byte strobe is issued; if low, frame_err pulses, the byte is discarded and the packet FSM returns to WAIT_HDR.
REQ-018 After a STOP sample, the byte FSM SHALL return to IDLE the next cycle and accept a new start bit immediately.
REQ-019 Record format SHALL be 4 bytes: header 0xA5, HI (bits [5:0] = speed[13:8], bits [7:6] ignored), LO = speed[7:0], CHK = 0xA5^HI^LO.
REQ-020 Packet FSM states SHALL be WAIT_HDR, GET_HI, GET_LO, GET_CHK.
REQ-021 In WAIT_HDR, any byte other than 0xA5 SHALL be discarded silently.
REQ-022 On the CHK byte, if the checksum matches: speed <= {HI[5:0],LO} and speed_valid pulses exactly 1 cycle after the CHK stop-bit sample; on mismatch, chk_err pulses in that same cycle and speed is unchanged.
REQ-023 Both the match and mismatch outcomes of REQ-022 SHALL return the FSM to WAIT_HDR.
REQ-024 Inter-byte timeout: in GET_HI/GET_LO/GET_CHK, if no byte strobe occurs within 40*CLKS_PER_BIT cycles, the FSM SHALL return to WAIT_HDR with no error pulse.
REQ-025 A 0xA5 byte received in GET_HI/GET_LO/GET_CHK SHALL be treated as data, not as a resync.
REQ-026 speed_valid, frame_err and chk_err SHALL be mutually exclusive in any cycle.

Reset
REQ-027 While reset=1: synchronizer flops = 1, byte FSM = IDLE, packet FSM = WAIT_HDR, all counters = 0, speed = 0, all pulse outputs = 0.
REQ-028 Reset asserted mid-byte or mid-record SHALL discard the partial data; the first record after release SHALL decode normally.

Structure
REQ-029 A shared package SHALL hold HDR_BYTE (0xA5), the byte-FSM and packet-FSM state encodings, and TIMEOUT_BITS (40).
REQ-030 The byte receiver SHALL be a sub-module uart_rx_byte (synchronizer, byte FSM, bit counter, baud counter) with outputs data[7:0], byte_strobe and stop_err.
REQ-031 uart_speed_rx SHALL contain only the packet FSM, checksum logic and timeout counter.

Verification
REQ-032 Bytes A5 01 2C 88 at 9600 baud -> exactly one speed_valid pulse, speed = 300, no error pulses.
REQ-033 Bytes A5 01 2C 89 -> one chk_err pulse, speed holds its previous value, and a following valid record decodes.
REQ-034 Byte with stop bit = 0 -> frame_err pulses once; a subsequent A5 00 50 F5 yields speed = 80.
REQ-035 A 1/4-bit low glitch on an idle line -> no strobe and no error; a following record decodes correctly.
REQ-036 A5 01, then idle for 50 bit times, then A5 00 64 C1 -> speed = 100 with no chk_err.
REQ-037 reset pulsed mid-LO byte -> speed = 0 and no pulses; the next full record A5 3F FF 65 -> speed = 16383.
